// File: rtl/word_vote_if.sv
// Bundle between the checker stage / display logic and the word vote filter.
// The master drives classification strobes and the abort; the slave (the
// filter) returns busy and the per-window word decision.
interface word_vote_if;
    logic        encode_valid;
    logic [19:0] encode;
    logic        clear;
    logic        busy;
    logic        word_valid;
    logic [4:0]  word_id;
    logic        word_reject;
    logic [3:0]  frame_errs;

    modport master (
        output encode_valid,
        output encode,
        output clear,
        input  busy,
        input  word_valid,
        input  word_id,
        input  word_reject,
        input  frame_errs
    );

    modport slave (
        input  encode_valid,
        input  encode,
        input  clear,
        output busy,
        output word_valid,
        output word_id,
        output word_reject,
        output frame_errs
    );
endinterface

// File: rtl/word_vote_filter.sv
// Word vote filter: collects per-class votes from FRAMES one-hot checker
// results, then scans the 20 counters one per cycle to pick the class with the
// most votes (lowest index on ties) and issues one registered decision per
// window. A window whose winner has fewer than THRESH votes is rejected.
module word_vote_filter #(
    parameter int FRAMES = 8,
    parameter int THRESH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    word_vote_if.slave    bus
);

    localparam int          NCLASS     = 20;
    localparam logic [3:0]  LAST_FRAME = 4'(FRAMES - 1);
    localparam logic [3:0]  THRESH_CNT = 4'(THRESH);
    localparam logic [4:0]  LAST_IDX   = 5'(NCLASS - 1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t       state_q, state_d;

    logic [3:0]   vote_w [NCLASS];
    logic [3:0]   err_q;
    logic [3:0]   frame_q;
    logic [4:0]   scan_idx_q;
    logic [3:0]   best_cnt_q;
    logic [4:0]   best_idx_q;
    logic [3:0]   scan_vote;

    logic         busy_q;
    logic         word_valid_q;
    logic [4:0]   word_id_q;
    logic         word_reject_q;
    logic [3:0]   frame_errs_q;

    logic         enc_onehot;
    logic         strobe_take;
    logic         window_end;
    logic         scan_step;
    logic         decide;

    // Strobe qualification: only COLLECT accepts strobes, and clear wins over
    // a simultaneous strobe. A DONE-exit edge is not COLLECT, so that strobe
    // is dropped as well.
    always_comb begin
        enc_onehot  = (bus.encode != 20'd0) &&
                      ((bus.encode & (bus.encode - 20'd1)) == 20'd0);
        strobe_take = (state_q == ST_COLLECT) && bus.encode_valid && !bus.clear;
        window_end  = strobe_take && (frame_q == LAST_FRAME);
        scan_step   = (state_q == ST_SCAN) && !bus.clear;
        decide      = (state_q == ST_DONE) && !bus.clear;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: clear aborts SCAN/DONE back to COLLECT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: begin
                if (window_end) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bus.clear) begin
                    state_d = ST_COLLECT;
                end else if (scan_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_COLLECT;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // One 4-bit vote counter per class; FRAMES <= 15 so none can wrap.
    // Counters are wiped on clear and when the decision is issued.
    generate
        for (genvar gi = 0; gi < NCLASS; gi++) begin : g_vote
            logic [3:0] cnt_q;

            // Count one-hot strobes that select this class.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= 4'd0;
                end else if (bus.clear || (state_q == ST_DONE)) begin
                    cnt_q <= 4'd0;
                end else if (strobe_take && enc_onehot && bus.encode[gi]) begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end

            assign vote_w[gi] = cnt_q;
        end
    endgenerate

    // Count non-one-hot strobes in the window, saturating at 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 4'd0;
        end else if (bus.clear || (state_q == ST_DONE)) begin
            err_q <= 4'd0;
        end else if (strobe_take && !enc_onehot && (err_q != 4'hF)) begin
            err_q <= err_q + 4'd1;
        end
    end

    // Count accepted strobes; wraps to 0 on the strobe that closes the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 4'd0;
        end else if (bus.clear) begin
            frame_q <= 4'd0;
        end else if (strobe_take) begin
            frame_q <= (frame_q == LAST_FRAME) ? 4'd0 : frame_q + 4'd1;
        end
    end

    // Read port into the vote counters for the class currently being scanned.
    always_comb begin
        scan_vote = 4'd0;
        for (int k = 0; k < NCLASS; k++) begin
            if (scan_idx_q == 5'(k)) begin
                scan_vote = vote_w[k];
            end
        end
    end

    // Sequential max search; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_q <= 5'd0;
            best_cnt_q <= 4'd0;
            best_idx_q <= 5'd0;
        end else if (bus.clear || window_end) begin
            scan_idx_q <= 5'd0;
            best_cnt_q <= 4'd0;
            best_idx_q <= 5'd0;
        end else if (scan_step) begin
            if (scan_vote > best_cnt_q) begin
                best_cnt_q <= scan_vote;
                best_idx_q <= scan_idx_q;
            end
            if (scan_idx_q != LAST_IDX) begin
                scan_idx_q <= scan_idx_q + 5'd1;
            end
        end
    end

    // Registered decision outputs; values hold until the next decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= 1'b0;
            word_valid_q  <= 1'b0;
            word_id_q     <= 5'd0;
            word_reject_q <= 1'b0;
            frame_errs_q  <= 4'd0;
        end else begin
            busy_q       <= (state_d != ST_COLLECT);
            word_valid_q <= decide;
            if (decide) begin
                frame_errs_q <= err_q;
                if (best_cnt_q >= THRESH_CNT) begin
                    word_id_q     <= best_idx_q + 5'd1;
                    word_reject_q <= 1'b0;
                end else begin
                    word_id_q     <= 5'd0;
                    word_reject_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.word_id     = word_id_q;
    assign bus.word_reject = word_reject_q;
    assign bus.frame_errs  = frame_errs_q;

endmodule

// File: tb/tb_word_vote_filter.sv
// Directed bench for word_vote_filter. Two instances run in lock-step on the
// same stimulus: one with THRESH=5, one with THRESH=4 for the threshold case.
`timescale 1ns/1ps
module tb_word_vote_filter;

    logic        clk;
    logic        rst_n;
    logic        ev;
    logic [19:0] enc;
    logic        clr;

    int n_cmp;
    int n_err;

    word_vote_if bus_a ();
    word_vote_if bus_b ();

    assign bus_a.encode_valid = ev;
    assign bus_a.encode       = enc;
    assign bus_a.clear        = clr;
    assign bus_b.encode_valid = ev;
    assign bus_b.encode       = enc;
    assign bus_b.clear        = clr;

    word_vote_filter #(.FRAMES(8), .THRESH(5)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    word_vote_filter #(.FRAMES(8), .THRESH(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one strobe sampled at the next edge, then idle for gap cycles.
    task automatic strobe(input logic [19:0] v, input int gap);
        ev  = 1'b1;
        enc = v;
        tick();
        ev  = 1'b0;
        enc = 20'd0;
        repeat (gap) tick();
    endtask

    // Eight strobes of the same value; ends just after the closing edge.
    task automatic window8(input logic [19:0] v, input int gap);
        for (int i = 0; i < 8; i++) strobe(v, (i == 7) ? 0 : gap);
    endtask

    // Wait (bounded) for a decision pulse and check its contents.
    task automatic expect_word(input string tag, input int exp_lat,
                               input logic [4:0] id_a, input logic rej_a,
                               input logic [4:0] id_b, input logic rej_b,
                               input logic [3:0] errs);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (bus_a.word_valid) seen = 1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            if (exp_lat > 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
            check({tag, "_id"},   32'(bus_a.word_id),     32'(id_a));
            check({tag, "_rej"},  32'(bus_a.word_reject), 32'(rej_a));
            check({tag, "_errs"}, 32'(bus_a.frame_errs),  32'(errs));
            check({tag, "_idB"},  32'(bus_b.word_id),     32'(id_b));
            check({tag, "_rejB"}, 32'(bus_b.word_reject), 32'(rej_b));
            tick();
            check({tag, "_pulse1"}, 32'(bus_a.word_valid), 32'd0);
        end
    endtask

    initial begin
        int busy_cnt;
        int early;
        int pulses;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ev    = 1'b0;
        enc   = 20'd0;
        clr   = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_valid", 32'(bus_a.word_valid), 32'd0);
        check("rst_id",    32'(bus_a.word_id),    32'd0);
        check("rst_rej",   32'(bus_a.word_reject), 32'd0);
        check("rst_errs",  32'(bus_a.frame_errs), 32'd0);
        check("rst_busy",  32'(bus_a.busy),       32'd0);
        rst_n = 1'b1;
        tick();

        // 1: directed win, gaps of 3, timing and busy width
        window8(20'h00040, 3);
        busy_cnt = bus_a.busy ? 1 : 0;
        early = 0;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (bus_a.busy) busy_cnt++;
            if (i < 21 && bus_a.word_valid) early++;
            if (i == 21) begin
                check("t1_valid", 32'(bus_a.word_valid), 32'd1);
                check("t1_id",    32'(bus_a.word_id),    32'd7);
                check("t1_rej",   32'(bus_a.word_reject), 32'd0);
                check("t1_errs",  32'(bus_a.frame_errs), 32'd0);
            end
        end
        check("t1_early", 32'(early), 32'd0);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd21);
        tick();
        check("t1_pulse1", 32'(bus_a.word_valid), 32'd0);
        check("t1_hold_id", 32'(bus_a.word_id), 32'd7);

        // 2: mixed window with invalid frames
        for (int i = 0; i < 5; i++) strobe(20'h00001, 1);
        strobe(20'h00000, 1);
        strobe(20'h00000, 1);
        strobe(20'h00011, 0);
        expect_word("t2", 21, 5'd1, 1'b0, 5'd1, 1'b0, 4'd3);

        // 3: tie between class 3 and 10 at 4 votes each
        for (int i = 0; i < 4; i++) strobe(20'h00004, 1);
        for (int i = 0; i < 4; i++) strobe(20'h00200, (i == 3) ? 0 : 1);
        expect_word("t3", 21, 5'd0, 1'b1, 5'd3, 1'b0, 4'd0);

        // 4: strobes during SCAN are dropped
        window8(20'h80000, 1);
        for (int i = 0; i < 5; i++) strobe(20'h00001, 1);
        expect_word("t4a", 11, 5'd20, 1'b0, 5'd20, 1'b0, 4'd0);
        window8(20'h00002, 1);
        expect_word("t4b", 21, 5'd2, 1'b0, 5'd2, 1'b0, 4'd0);

        // Strobe coinciding with the DONE-exit edge is dropped
        window8(20'h01000, 1);
        repeat (20) tick();
        strobe(20'h00001, 0);
        check("tD_valid", 32'(bus_a.word_valid), 32'd1);
        check("tD_id",    32'(bus_a.word_id),    32'd13);
        tick();
        window8(20'h00020, 1);
        expect_word("tD", 21, 5'd6, 1'b0, 5'd6, 1'b0, 4'd0);

        // 5a: clear in COLLECT discards partial window
        for (int i = 0; i < 6; i++) strobe(20'h00008, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_clr_novalid", 32'(bus_a.word_valid), 32'd0);
        window8(20'h00010, 1);
        expect_word("t5a", 21, 5'd5, 1'b0, 5'd5, 1'b0, 4'd0);

        // 5b: clear at SCAN cycle 10 aborts the decision
        window8(20'h00040, 1);
        repeat (10) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_a.word_valid) pulses++;
            tick();
        end
        check("t5b_pulses", 32'(pulses), 32'd0);
        check("t5b_hold_id", 32'(bus_a.word_id), 32'd5);
        check("t5b_busy",    32'(bus_a.busy),    32'd0);
        window8(20'h00800, 1);
        expect_word("t5c", 21, 5'd12, 1'b0, 5'd12, 1'b0, 4'd0);

        // 6: asynchronous reset at scan_idx 7
        window8(20'h00400, 1);
        repeat (7) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_id",    32'(bus_a.word_id),    32'd0);
        check("t6_valid", 32'(bus_a.word_valid), 32'd0);
        check("t6_busy",  32'(bus_a.busy),       32'd0);
        check("t6_rej",   32'(bus_a.word_reject), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        window8(20'h00100, 1);
        expect_word("t6", 21, 5'd9, 1'b0, 5'd9, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_vote_filter.md
Name: word_vote_filter

Overview:
- Downstream consumer of the checker stage's 20-bit one-hot `encode` result.
- Accumulates per-class votes over a window of FRAMES classification strobes, then scans the 20 vote counters sequentially and emits one stable word decision per window.
- A decision is either a word index (1..20) or a reject (0). A reject is issued when no class reaches THRESH votes.
- Feeds the word-display/command logic, replacing raw per-frame results that flicker.

Parameters:
FRAMES, 8, number of encode strobes per voting window (2..15)
THRESH, 5, minimum votes for the winning class to be accepted (1..FRAMES)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
encode_valid  input  1  one-cycle strobe: encode holds a fresh checker result
encode  input  20  checker result; bit i set means class i+1
clear  input  1  synchronous abort: discard current window
busy  output  1  high in SCAN and DONE; strobes are ignored while high
word_valid  output  1  one-cycle pulse: a decision is present on word_id/word_reject/frame_errs
word_id  output  5  winning class 1..20, or 0 on reject
word_reject  output  1  high when the winner's count < THRESH
frame_errs  output  4  count of non-one-hot frames in the decided window, saturating at 15

Behaviour:
- Reset (async, rst_n low):
  - All outputs are 0.
  - All vote counters, frame counter, scan index and best registers are 0.
  - State is COLLECT.
  - Applies at any point, including mid-SCAN; no word_valid is produced for an interrupted window.
- States: COLLECT, SCAN, DONE.
- COLLECT:
  - On an encode_valid strobe with encode exactly one-hot at bit i: vote[i] += 1.
  - On a strobe with zero or multiple bits set: no vote; the error counter increments, saturating at 15.
  - Every strobe, valid or not, increments frame_cnt.
  - A strobe sampled when frame_cnt == FRAMES-1 moves the block to SCAN. On that edge: frame_cnt <= 0, scan_idx <= 0, best_cnt <= 0, best_idx <= 0.
- SCAN (20 cycles, scan_idx 0..19):
  - Each edge: if vote[scan_idx] > best_cnt (strict), then best_cnt <= vote[scan_idx] and best_idx <= scan_idx.
  - The strict compare means the lowest index wins ties.
  - At scan_idx == 19 go to DONE; otherwise scan_idx += 1.
- DONE (1 cycle). On the exiting edge:
  - word_valid <= 1.
  - If best_cnt >= THRESH: word_id <= best_idx+1 and word_reject <= 0. Otherwise word_id <= 0 and word_reject <= 1.
  - frame_errs <= error counter.
  - All vote counters and the error counter clear to 0.
  - State returns to COLLECT.
- Latency: the final strobe is sampled at edge E0. SCAN spans edges E0+1..E0+20. word_valid is high from E0+21 to E0+22, exactly one cycle.
- Output hold: word_id, word_reject and frame_errs hold their values until the next decision or reset. word_valid is 0 otherwise.
- Strobes while busy: ignored; no counter changes.
- A strobe on the same edge that DONE exits is also ignored. Counting restarts from the following edge.
- All-zero votes (every frame invalid): best_cnt = 0 < THRESH, so the result is a reject with word_id 0.
- clear:
  - In COLLECT: zero all counters; no output change.
  - In SCAN or DONE: abort to COLLECT, clear counters, suppress word_valid; previous outputs are held.
  - clear has priority over a simultaneous encode_valid.
- Counter widths: vote counters are 4 bits each and cannot overflow, since FRAMES ≤ 15. frame_cnt is 4 bits.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Directed win: 8 strobes of encode=20'h00040 with gaps of 3 cycles → one word_valid pulse 21 edges after the 8th strobe; word_id=7, word_reject=0, frame_errs=0; busy high for 21 cycles.
2. Mixed window:
   - Stimulus: 5×20'h00001, 2×20'h00000, 1×20'h00011.
   - Required: word_id=1, word_reject=0, frame_errs=3.
3. Tie and threshold:
   - Stimulus: 4×20'h00004 then 4×20'h00200. With THRESH=5 → word_id=0, word_reject=1. With THRESH=4 → word_id=3 (lowest index wins).
4. Busy drop: complete a window of class 20 (20'h80000); during SCAN drive 5 strobes of 20'h00001 → decision word_id=20. The next window, with 8 strobes of 20'h00002, yields word_id=2 with no leftover votes.
5. Clear: 6 strobes of 20'h00008, pulse clear, then 8 strobes of 20'h00010 → single decision word_id=5, count unaffected by the pre-clear frames. A clear asserted at SCAN cycle 10 → no word_valid; outputs keep their prior values.
6. Reset mid-SCAN: drop rst_n at scan_idx 7 → all outputs 0 immediately. After release, a full window of 20'h00100 → word_id=9.
